fp_mul64_seq: RTL
=================

# fp_mul64_seq

Sequential IEEE 754 double-precision multiplier: the multiply counterpart of the iterative fp64 divider, sharing its `ld`/`done` handshake and its unnormalized FP64X result format. It decodes two FP64 operands and forms the exact 106-bit significand product with a radix-16 shift-add loop, 14 iterations. It resolves specials and exponent over/underflow and presents a raw FP64X result for the existing `fpNormalize64` → `fpRound64` back end. It is a small-area alternative to the combinational multiplier, for FPUs that already sequence the divider.

## Interface
- No parameters. Widths come from fp64Pkg: EMSB=10, FMSB=51, FX=105.
- `clk` input, 1 bit: the single clock. Everything is rising-edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `ce` input, 1 bit: clock enable. When low, all state freezes, including the iteration counter and `done`.
- `ld` input, 1 bit: start pulse. Sampled only when `ce`=1.
- `a`, `b` input, 64 bits each (FP64): operands. Sampled on the `ld` edge.
- `o` output, 118 bits (FP64X): `{so[117], xo[116:106], mo[105:0]}`.
- `done` output, 1 bit: high when idle or when the result is valid.
- `overflow` output, 1 bit: exponent overflow for the current result.
- `underflow` output, 1 bit: exponent underflow for the current result.

## Operation
- States: IDLE → DECODE → MUL (14 cycles) → FINAL → IDLE.
- `ld` accepted with `ce`=1 while in any state: aborts any operation in flight, captures `a`/`b`, enters DECODE, clears `done`.
- DECODE:
  - Split the operands into sign, exponent and 53-bit fraction (hidden bit = exponent≠0).
  - Raise flags: zero, inf, NaN.
  - Effective exponent: xa' = xa | (denormal & nonzero); same for xb'.
  - ex = xa' + xb' − 1023, 13-bit signed.
- MUL:
  - Product register P, 110 bits, initialised to {54'b0, 3'b0, fractb}.
  - Each cycle: P ← ({P[109:56] + fracta·P[3:0], P[55:0]}) >> 4.
  - After 14 iterations P[105:0] = fracta·fractb exactly.
- FINAL:
  - under = ex[12].
  - over = (ex[10:0]==7FF | ex[11]) & ~ex[12].
  - Output fields are selected in the priority order given under Timing.
  - so = sa^sb. `overflow`=over, `underflow`=under.
- Result value: (−1)^so · mo · 2^(xo−1023−104). An mo in [2^104, 2^106) is normalised downstream.

## Timing
- `ld` on edge T → `done` low from T.
- FINAL runs on edge T+16. `o`, `overflow` and `underflow` update there, and `done` rises there.
- Latency: 16 `ce`-enabled cycles. `o` holds until the next `ld`.
- Reset (asynchronous):
  - `o`=0, `overflow`=0, `underflow`=0, `done`=1, state IDLE.
  - Reset mid-operation discards the operation; no result is produced.
- `ld` during MUL restarts. Only the last accepted operands produce a result.
- `ld` coincident with FINAL: the restart wins, `done` stays low, outputs are not updated.
- `ce` low stretches latency by the number of low cycles. A `ld` with `ce`=0 is ignored.
- FINAL priority, highest first:
  1. aNaN: xo=7FF, mo={1, a[51:0], 53'b0}.
  2. bNaN: xo=7FF, mo={1, b[51:0], 53'b0}.
  3. inf×0: xo=7FF, mo={1, qNaN|QINFZERO, 53'b0}.
  4. inf operand: xo=7FF, mo=0.
  5. zero operand: xo=0, mo=0.
  6. over: xo=7FF, mo=0.
  7. under: see Configuration.
  8. Otherwise: xo=ex[10:0], mo=P[105:0].

## Configuration
- `FPMUL_DENORM_EN` defined: under does not alter the result. xo=ex[10:0] and mo=P[105:0] are passed through so the normalizer can denormalize. `underflow` still asserts.
- `FPMUL_DENORM_EN` undefined: under flushes to zero, xo=0 and mo=0.
- Special-value handling is the same in both builds.

## Test plan
- Normal operands: a=3FF8000000000000 (1.5), b=4000000000000000 (2.0), `ld` → `done` rises 16 cycles later. Required: so=0, xo=400, mo=3<<103, overflow=0, underflow=0.
- Special inputs:
  - a=7FF0000000000000 (inf), b=0 → xo=7FF, mo MSB=1 with the QINFZERO code set.
  - a=7FF4000000000001 (NaN), b=3FF0000000000000 (1.0) → mo={1, 4000000000001, 53'b0}.
- Overflow: a=b=7FE0000000000000 → overflow=1, xo=7FF, mo=0.
- Underflow: a=b=0010000000000000 → underflow=1.
  - Macro undefined: xo=0, mo=0.
  - Macro defined: xo=ex[10:0] for ex=−1021, mo=1<<104.
- Restart: `ld` (1.5×2.0), then a second `ld` (1.0×1.0) 6 cycles later → `done` rises exactly 16 cycles after the second `ld`, with xo=3FF, mo=1<<104. The first result never appears.
- Stall and reset:
  - `ce` held low for 5 cycles mid-MUL → `done` is delayed by exactly 5 cycles and the result is unchanged.
  - `rst` pulsed mid-MUL → `done`=1 and `o`=0 immediately, with no later update.

Source files
------------

// File: rtl/fp_mul64_seq.sv
// fp_mul64_seq: iterative FP64 multiplier with an ld/done handshake.
// Produces an unnormalized FP64X result {so, xo[10:0], mo[105:0]} for the
// normalize/round back end. The significand product is built four bits per
// cycle over 14 cycles.
// Build option: FPMUL_DENORM_EN, when defined, passes exponent-underflow
// results through unflushed so the normalizer can denormalize them.
// Without it, underflow flushes to zero.
module fp_mul64_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         ld,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [117:0] o,
  output logic         done,
  output logic         overflow,
  output logic         underflow
);
  localparam int EMSB = 10;
  localparam int FMSB = 51;
  localparam int FX   = 105;

  // NaN payload for inf*0: quiet bit plus the invalid-operation code
  localparam logic [FMSB:0] QNAN     = 52'h8000000000000;
  localparam logic [FMSB:0] QINFZERO = 52'h0000000000003;

  typedef enum logic [1:0] {IDLE, DECODE, MUL, FINAL} state_t;
  state_t state, state_nxt;

  logic [63:0]     a_r, b_r;
  logic [FMSB+1:0] fa;
  logic [109:0]    p, p_nxt;
  logic [56:0]     madd;
  logic [12:0]     ex;
  logic [5:0]      cls;   // {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero}
  logic [3:0]      cnt;

  logic [EMSB:0]   xa, xb, xa_e, xb_e;
  logic [FMSB+1:0] fa_d, fb_d;
  logic [12:0]     ex_d;
  logic [5:0]      cls_d;

  logic            over, under;
  logic [EMSB:0]   xo_f;
  logic [FX:0]     mo_f;

  // operand decode: hidden bit, effective exponent, class flags, biased exponent sum
  always_comb begin
    xa    = a_r[62:52];
    xb    = b_r[62:52];
    fa_d  = {|xa, a_r[FMSB:0]};
    fb_d  = {|xb, b_r[FMSB:0]};
    // denormals behave as exponent 1 with no hidden bit
    xa_e  = xa | {{EMSB{1'b0}}, ~|xa & |a_r[FMSB:0]};
    xb_e  = xb | {{EMSB{1'b0}}, ~|xb & |b_r[FMSB:0]};
    ex_d  = {2'b0, xa_e} + {2'b0, xb_e} - 13'd1023;
    cls_d = {&xa & |a_r[FMSB:0], &xb & |b_r[FMSB:0],
             &xa & ~|a_r[FMSB:0], &xb & ~|b_r[FMSB:0],
             ~|xa & ~|a_r[FMSB:0], ~|xb & ~|b_r[FMSB:0]};
  end

  // one radix-16 shift-add step; the sum is kept 57 bits wide so its carries
  // land in the top of P after the shift
  always_comb begin
    madd  = {3'b0, p[109:56]} + 57'(fa) * 57'(p[3:0]);
    p_nxt = {1'b0, madd, p[55:4]};
  end

  // result field selection, specials first
  always_comb begin
    under = ex[12];
    over  = ((ex[EMSB:0] == 11'h7FF) | ex[11]) & ~ex[12];
    xo_f  = ex[EMSB:0];
    mo_f  = p[FX:0];
    if (cls[5]) begin
      xo_f = '1;
      mo_f = {1'b1, a_r[FMSB:0], {(FMSB+2){1'b0}}};
    end else if (cls[4]) begin
      xo_f = '1;
      mo_f = {1'b1, b_r[FMSB:0], {(FMSB+2){1'b0}}};
    end else if ((cls[3] & cls[0]) | (cls[2] & cls[1])) begin
      xo_f = '1;
      mo_f = {1'b1, QNAN | QINFZERO, {(FMSB+2){1'b0}}};
    end else if (cls[3] | cls[2]) begin
      xo_f = '1;
      mo_f = '0;
    end else if (cls[1] | cls[0]) begin
      xo_f = '0;
      mo_f = '0;
    end else if (over) begin
      xo_f = '1;
      mo_f = '0;
    end else if (under) begin
`ifdef FPMUL_DENORM_EN
      xo_f = ex[EMSB:0];
      mo_f = p[FX:0];
`else
      xo_f = '0;
      mo_f = '0;
`endif
    end
  end

  // next state; a load restarts from any state, including FINAL
  always_comb begin
    state_nxt = state;
    if (ld) state_nxt = DECODE;
    else begin
      case (state)
        DECODE:  state_nxt = MUL;
        MUL:     if (cnt == 4'd13) state_nxt = FINAL;
        FINAL:   state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  // operand capture, decode, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      fa        <= '0;
      p         <= '0;
      ex        <= '0;
      cls       <= '0;
      cnt       <= '0;
      o         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      done      <= 1'b1;
    end else if (ce) begin
      if (ld) begin
        a_r  <= a;
        b_r  <= b;
        done <= 1'b0;
      end else begin
        case (state)
          DECODE: begin
            fa  <= fa_d;
            p   <= {57'b0, fb_d};
            ex  <= ex_d;
            cls <= cls_d;
            cnt <= '0;
          end
          MUL: begin
            p   <= p_nxt;
            cnt <= cnt + 4'd1;
          end
          FINAL: begin
            o         <= {a_r[63] ^ b_r[63], xo_f, mo_f};
            overflow  <= over;
            underflow <= under;
            done      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
